mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning memory data width (byte-wide memory).
REQ-003 The block SHALL have parameter MAX_LOCK, default 4, meaning the maximum number of consecutive beats per grant, range 1..15.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, reset; synchronous and active-high.
REQ-006 The block SHALL have ports cpu_req / dma_req, input, 1 each, meaning access requested this cycle.
REQ-007 The block SHALL have ports cpu_lock / dma_lock, input, 1 each, meaning keep the grant after this beat.
REQ-008 The block SHALL have ports cpu_we / dma_we, input, 1 each, meaning 1=write, 0=read.
REQ-009 The block SHALL have ports cpu_addr / dma_addr, input, ADDR_W each, meaning access address.
REQ-010 The block SHALL have ports cpu_wdata / dma_wdata, input, DATA_W each, meaning write data.
REQ-011 The block SHALL have ports cpu_gnt / dma_gnt, output, 1 each, meaning the requester owns the bus this cycle.
REQ-012 The block SHALL have ports cpu_rdata / dma_rdata, output, DATA_W each, meaning registered read data.
REQ-013 The block SHALL have ports cpu_rvalid / dma_rvalid, output, 1 each, meaning a one-cycle pulse when rdata is valid.
REQ-014 The block SHALL have port mem_addr, output, ADDR_W, meaning memory address.
REQ-015 The block SHALL have port mem_wdata, output, DATA_W, meaning memory write data.
REQ-016 The block SHALL have ports mem_read / mem_write, output, 1 each, meaning memory strobes.
REQ-017 The block SHALL have port mem_rdata, input, DATA_W, meaning memory read data, valid in the same cycle as mem_read.

Function
REQ-018 FSM states SHALL be IDLE, OWN_CPU and OWN_DMA; gnt outputs SHALL be decoded from the state only (cpu_gnt = OWN_CPU, dma_gnt = OWN_DMA).
REQ-019 A beat SHALL occur in any cycle where the owner's req=1.
- mem_addr and mem_wdata are the owner's inputs.
- mem_read = req & ~we; mem_write = req & we.
REQ-020 Outside a beat, mem_read and mem_write SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-021 On a read beat, mem_rdata SHALL be registered into the owner's rdata, and its rvalid SHALL pulse exactly one cycle later.
REQ-022 A non-owner's rdata SHALL hold its previous value.
REQ-023 Arbitration pick: if only one req is high, that requester wins; if both are high, the requester other than last_owner wins; if neither, go to IDLE.
REQ-024 From IDLE, the pick SHALL take effect on the next cycle (one-cycle grant latency).
REQ-025 Release SHALL occur on any of:
- a beat with lock=0;
- the owner's req=0 while granted;
- the MAX_LOCK-th consecutive beat.
REQ-026 On release, last_owner SHALL update to the releasing requester, and the next state SHALL be the pick using the updated last_owner, giving a direct handover with no IDLE bubble.
REQ-027 On a forced release (MAX_LOCK reached), the other requester SHALL win if it is requesting; otherwise the same owner SHALL be re-granted with a fresh count.
REQ-028 The beat counter (4 bits) SHALL clear on every grant change and on re-grant, and SHALL increment per beat; it SHALL never wrap.
REQ-029 Both gnt outputs SHALL never be 1 in the same cycle.
REQ-030 A requester's req and lock inputs SHALL be ignored while it is not granted.

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL go to IDLE with last_owner=DMA (so CPU wins the first tie) and beat count 0.
REQ-032 Under reset, every output SHALL be 0: gnt, rvalid, rdata, mem_addr, mem_wdata, mem_read and mem_write.
REQ-033 Reset asserted mid-beat or mid-lock SHALL abort the grant, and any pending rvalid SHALL be suppressed.

Structure
REQ-034 State encoding, owner encoding (CPU=0, DMA=1) and the default widths SHALL live in shared package srp16_bus_pkg.
REQ-035 The two-way round-robin pick SHALL be a package function; no sub-module is required.

Verification
REQ-036 Reset released with cpu_req=dma_req=1, lock=0 -> cycle 1 cpu_gnt=1, cycle 2 dma_gnt=1, alternating every cycle thereafter.
REQ-037 CPU read, addr 0x0100, mem_rdata=0x5A, lock=1 then 0 at 0x0101 (0xC3) -> two beats with no DMA grant between them; cpu_rvalid pulses with 0x5A then 0xC3.
REQ-038 CPU holds lock=1 continuously with MAX_LOCK=4 and dma_req=1 -> exactly 4 CPU beats, then dma_gnt on the next cycle.
REQ-039 DMA write, addr 0x8000, wdata 0x7E while cpu_req=0 -> mem_write=1, mem_addr=0x8000, mem_wdata=0x7E, with mem_read=0 throughout.
REQ-040 Reset asserted during a CPU read beat -> next cycle all outputs 0, no cpu_rvalid pulse.
REQ-041 Random req/lock over 10k cycles -> never both gnt high; no requester is starved beyond MAX_LOCK+1 cycles while its req is held.

Source files
------------

// File: rtl/srp16_bus_pkg.sv
// srp16_bus_pkg: shared widths, FSM/owner encodings and two-way round-robin pick for the memory bus arbiter
package srp16_bus_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int MAX_LOCK_DEF = 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN_CPU = 2'd1;
  localparam logic [1:0] OWN_DMA = 2'd2;
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;
  function automatic logic [1:0] rr_pick(input logic cpu_req, input logic dma_req, input logic last_owner);
    return cpu_req && dma_req ? (last_owner == OWNER_CPU ? OWN_DMA : OWN_CPU) :
           cpu_req ? OWN_CPU : dma_req ? OWN_DMA : IDLE;
  endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: cpu/dma requester signals (req, lock, we, addr, wdata -> gnt, rdata, rvalid) and memory side (addr, wdata, read, write <- rdata)
interface mem_bus_arbiter_if
  import srp16_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              cpu_req, cpu_lock, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dma_req, dma_lock, dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt, dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read, mem_write;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  cpu_req, cpu_lock, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_lock, dma_we, dma_addr, dma_wdata, mem_rdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid, dma_gnt, dma_rdata, dma_rvalid,
    output mem_addr, mem_wdata, mem_read, mem_write
  );
  modport master (
    output cpu_req, cpu_lock, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_lock, dma_we, dma_addr, dma_wdata, mem_rdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid, dma_gnt, dma_rdata, dma_rvalid,
    input  mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester (cpu/dma) round-robin memory arbiter with lock bursts; ports clk, reset (sync, active-high), bus (slave modport)
module mem_bus_arbiter
  import srp16_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input logic clk,
  input logic reset,
  mem_bus_arbiter_if.slave bus
);
  logic [1:0] state, state_n;
  logic last_owner, o, req, lock, we, beat, rel;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  always_comb begin
    o = state == OWN_DMA;
    req = o ? bus.dma_req : bus.cpu_req;
    lock = o ? bus.dma_lock : bus.cpu_lock;
    we = o ? bus.dma_we : bus.cpu_we;
    beat = state != IDLE && req;
    rel = state != IDLE && (!req || !lock || cnt == 4'(MAX_LOCK - 1));
    state_n = state == IDLE ? rr_pick(bus.cpu_req, bus.dma_req, last_owner) :
              rel ? rr_pick(bus.cpu_req, bus.dma_req, o) : state;
    addr = beat ? (o ? bus.dma_addr : bus.cpu_addr) : '0;
    wdata = beat ? (o ? bus.dma_wdata : bus.cpu_wdata) : '0;
  end
  assign bus.cpu_gnt = state == OWN_CPU;
  assign bus.dma_gnt = state == OWN_DMA;
  assign bus.mem_addr = addr;
  assign bus.mem_wdata = wdata;
  assign bus.mem_read = beat && !we;
  assign bus.mem_write = beat && we;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_owner <= OWNER_DMA;
      cnt <= '0;
      bus.cpu_rvalid <= 1'b0;
      bus.dma_rvalid <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dma_rdata <= '0;
    end else begin
      state <= state_n;
      if (rel) last_owner <= o;
      cnt <= (state_n != state || rel) ? '0 : cnt + {3'b0, beat};
      bus.cpu_rvalid <= beat && !we && !o;
      bus.dma_rvalid <= beat && !we && o;
      if (beat && !we && !o) bus.cpu_rdata <= bus.mem_rdata;
      if (beat && !we && o) bus.dma_rdata <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter against a behavioural ownership model
module tb_mem_bus_arbiter;
  localparam int MAX_LOCK = 4;
  logic clk = 0;
  logic reset = 1;
  int total = 0, passed = 0;
  mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();
  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_LOCK(MAX_LOCK)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int m_own, m_last, m_streak;
  logic m_req, m_lock, m_we, m_done, m_cv, m_dv;
  logic [7:0] m_crd, m_drd;
  function automatic int choose(logic c, logic d, int last);
    return (c && d) ? (last == 1 ? 2 : 1) : c ? 1 : d ? 2 : 0;
  endfunction
  always_comb begin
    m_req = m_own == 1 ? bus.cpu_req : m_own == 2 ? bus.dma_req : 1'b0;
    m_lock = m_own == 1 ? bus.cpu_lock : m_own == 2 ? bus.dma_lock : 1'b0;
    m_we = m_own == 1 ? bus.cpu_we : m_own == 2 ? bus.dma_we : 1'b0;
    m_done = !m_req || !m_lock || (m_streak + 1 == MAX_LOCK);
  end
  always @(posedge clk) begin
    if (reset) begin
      m_own <= 0; m_last <= 2; m_streak <= 0;
      m_cv <= 0; m_dv <= 0; m_crd <= 0; m_drd <= 0;
    end else begin
      m_cv <= m_own == 1 && m_req && !m_we;
      m_dv <= m_own == 2 && m_req && !m_we;
      if (m_own == 1 && m_req && !m_we) m_crd <= bus.mem_rdata;
      if (m_own == 2 && m_req && !m_we) m_drd <= bus.mem_rdata;
      if (m_own == 0) m_own <= choose(bus.cpu_req, bus.dma_req, m_last);
      else if (m_done) begin
        m_last <= m_own;
        m_own <= choose(bus.cpu_req, bus.dma_req, m_own);
        m_streak <= 0;
      end else m_streak <= m_streak + 1;
    end
  end

  task automatic clear();
    bus.cpu_req = 0; bus.cpu_lock = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dma_req = 0; bus.dma_lock = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
    bus.mem_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    clear();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    clear();
    repeat (2) @(negedge clk);
    bus.cpu_req = 1; bus.dma_req = 1; bus.cpu_addr = 16'h1234; bus.cpu_wdata = 8'h55;
    #1;
    total++;
    if ({bus.cpu_gnt, bus.dma_gnt, bus.cpu_rvalid, bus.dma_rvalid, bus.mem_read, bus.mem_write} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {bus.cpu_gnt, bus.dma_gnt, bus.cpu_rvalid, bus.dma_rvalid, bus.mem_read, bus.mem_write});
    else passed++;
    total++;
    if ({bus.cpu_rdata, bus.dma_rdata, bus.mem_addr, bus.mem_wdata} !== 40'h0)
      $display("FAIL reset_data: got %h want 0", {bus.cpu_rdata, bus.dma_rdata, bus.mem_addr, bus.mem_wdata});
    else passed++;
  endtask

  task automatic test_alternate();
    do_reset();
    bus.cpu_req = 1; bus.dma_req = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      total++;
      if ({bus.cpu_gnt, bus.dma_gnt} !== (i % 2 == 0 ? 2'b10 : 2'b01))
        $display("FAIL alternate[%0d]: got %b want %b", i, {bus.cpu_gnt, bus.dma_gnt}, (i % 2 == 0 ? 2'b10 : 2'b01));
      else passed++;
    end
  endtask

  task automatic test_cpu_lock_read();
    do_reset();
    bus.cpu_req = 1; bus.cpu_lock = 1; bus.cpu_addr = 16'h0100; bus.dma_req = 1;
    @(negedge clk);
    bus.mem_rdata = 8'h5A;
    #1;
    total++;
    if ({bus.cpu_gnt, bus.dma_gnt, bus.mem_read, bus.mem_addr} !== {3'b101, 16'h0100})
      $display("FAIL lock_beat1: got %h want %h", {bus.cpu_gnt, bus.dma_gnt, bus.mem_read, bus.mem_addr}, {3'b101, 16'h0100});
    else passed++;
    @(negedge clk);
    bus.cpu_lock = 0; bus.cpu_addr = 16'h0101; bus.mem_rdata = 8'hC3;
    #1;
    total++;
    if ({bus.cpu_gnt, bus.dma_gnt, bus.mem_read, bus.mem_addr, bus.cpu_rvalid, bus.cpu_rdata} !== {3'b101, 16'h0101, 1'b1, 8'h5A})
      $display("FAIL lock_beat2: got %h want %h", {bus.cpu_gnt, bus.dma_gnt, bus.mem_read, bus.mem_addr, bus.cpu_rvalid, bus.cpu_rdata}, {3'b101, 16'h0101, 1'b1, 8'h5A});
    else passed++;
    @(negedge clk);
    bus.cpu_req = 0; bus.dma_req = 0;
    #1;
    total++;
    if ({bus.cpu_gnt, bus.dma_gnt, bus.mem_read, bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, bus.dma_rdata} !== {4'b0101, 8'hC3, 1'b0, 8'h00})
      $display("FAIL lock_handover: got %h want %h", {bus.cpu_gnt, bus.dma_gnt, bus.mem_read, bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, bus.dma_rdata}, {4'b0101, 8'hC3, 1'b0, 8'h00});
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b0, 8'hC3})
      $display("FAIL rvalid_pulse: got %h want %h", {bus.cpu_rvalid, bus.cpu_rdata}, {1'b0, 8'hC3});
    else passed++;
  endtask

  task automatic test_max_lock();
    do_reset();
    bus.cpu_req = 1; bus.cpu_lock = 1; bus.cpu_we = 1; bus.dma_req = 1;
    for (int i = 0; i <= MAX_LOCK; i++) begin
      @(negedge clk); #1;
      total++;
      if ({bus.cpu_gnt, bus.dma_gnt, bus.mem_write} !== (i < MAX_LOCK ? 3'b101 : 3'b010))
        $display("FAIL max_lock[%0d]: got %b want %b", i, {bus.cpu_gnt, bus.dma_gnt, bus.mem_write}, (i < MAX_LOCK ? 3'b101 : 3'b010));
      else passed++;
    end
  endtask

  task automatic test_dma_write();
    do_reset();
    bus.dma_req = 1; bus.dma_lock = 1; bus.dma_we = 1; bus.dma_addr = 16'h8000; bus.dma_wdata = 8'h7E;
    #1;
    total++;
    if ({bus.dma_gnt, bus.mem_read, bus.mem_write, bus.mem_addr} !== 19'h0)
      $display("FAIL dma_idle: got %h want 0", {bus.dma_gnt, bus.mem_read, bus.mem_write, bus.mem_addr});
    else passed++;
    for (int i = 0; i < 2 * MAX_LOCK + 1; i++) begin
      @(negedge clk); #1;
      total++;
      if ({bus.cpu_gnt, bus.dma_gnt, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== {4'b0101, 16'h8000, 8'h7E})
        $display("FAIL dma_write[%0d]: got %h want %h", i, {bus.cpu_gnt, bus.dma_gnt, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata}, {4'b0101, 16'h8000, 8'h7E});
      else passed++;
    end
  endtask

  task automatic test_reset_mid_beat();
    do_reset();
    bus.cpu_req = 1; bus.cpu_lock = 1; bus.cpu_addr = 16'h0200;
    @(negedge clk);
    bus.mem_rdata = 8'h11;
    @(negedge clk);
    bus.mem_rdata = 8'h99;
    #1;
    total++;
    if ({bus.cpu_gnt, bus.mem_read, bus.cpu_rvalid, bus.cpu_rdata} !== {3'b111, 8'h11})
      $display("FAIL pre_reset: got %h want %h", {bus.cpu_gnt, bus.mem_read, bus.cpu_rvalid, bus.cpu_rdata}, {3'b111, 8'h11});
    else passed++;
    reset = 1;
    @(negedge clk); #1;
    total++;
    if ({bus.cpu_gnt, bus.dma_gnt, bus.mem_read, bus.mem_write, bus.cpu_rvalid, bus.cpu_rdata, bus.mem_addr} !== 29'h0)
      $display("FAIL mid_reset: got %h want 0", {bus.cpu_gnt, bus.dma_gnt, bus.mem_read, bus.mem_write, bus.cpu_rvalid, bus.cpu_rdata, bus.mem_addr});
    else passed++;
    reset = 0;
    clear();
  endtask

  task automatic test_random();
    int cw = 0, dw = 0;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      reset = $urandom_range(0, 499) == 0;
      if (!bus.cpu_req) bus.cpu_req = $urandom_range(0, 9) < 3;
      else if (bus.cpu_gnt) bus.cpu_req = $urandom_range(0, 9) < 7;
      if (!bus.dma_req) bus.dma_req = $urandom_range(0, 9) < 3;
      else if (bus.dma_gnt) bus.dma_req = $urandom_range(0, 9) < 7;
      bus.cpu_lock = $urandom_range(0, 9) < 6; bus.dma_lock = $urandom_range(0, 9) < 6;
      bus.cpu_we = 1'($urandom); bus.dma_we = 1'($urandom);
      bus.cpu_addr = 16'($urandom); bus.dma_addr = 16'($urandom);
      bus.cpu_wdata = 8'($urandom); bus.dma_wdata = 8'($urandom);
      bus.mem_rdata = 8'($urandom);
      #1;
      total++;
      if ({bus.cpu_gnt, bus.dma_gnt} !== {m_own == 1, m_own == 2})
        $display("FAIL rnd_gnt[%0d]: got %b want %b", i, {bus.cpu_gnt, bus.dma_gnt}, {m_own == 1, m_own == 2});
      else passed++;
      total++;
      if (bus.cpu_gnt && bus.dma_gnt) $display("FAIL rnd_excl[%0d]: got 11 want not 11", i);
      else passed++;
      total++;
      if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== (m_req ? {!m_we, m_we, (m_own == 1 ? {bus.cpu_addr, bus.cpu_wdata} : {bus.dma_addr, bus.dma_wdata})} : 26'h0))
        $display("FAIL rnd_mem[%0d]: got %h want %h", i, {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata},
                 (m_req ? {!m_we, m_we, (m_own == 1 ? {bus.cpu_addr, bus.cpu_wdata} : {bus.dma_addr, bus.dma_wdata})} : 26'h0));
      else passed++;
      total++;
      if ({bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, bus.dma_rdata} !== {m_cv, m_crd, m_dv, m_drd})
        $display("FAIL rnd_rd[%0d]: got %h want %h", i, {bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, bus.dma_rdata}, {m_cv, m_crd, m_dv, m_drd});
      else passed++;
      cw = reset ? 0 : (bus.cpu_req && !bus.cpu_gnt) ? cw + 1 : 0;
      dw = reset ? 0 : (bus.dma_req && !bus.dma_gnt) ? dw + 1 : 0;
      total++;
      if (cw > MAX_LOCK + 1 || dw > MAX_LOCK + 1)
        $display("FAIL rnd_starve[%0d]: got wait cpu=%0d dma=%0d want <= %0d", i, cw, dw, MAX_LOCK + 1);
      else passed++;
    end
    reset = 0;
    clear();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_cpu_lock_read();
    test_max_lock();
    test_dma_write();
    test_reset_mid_beat();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
